instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 112 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks PC through instruction memory up to
// LAST_ADDR, buffering fetched {pc, instr} pairs in a 2-entry FIFO for decode.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] LAST_ADDR = 32'd20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc0, instr0, pc1, instr1;
  logic [1:0]  count;
  logic        pop, push;
  logic [31:0] br_target;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? pc0    : '0;
  assign out_instr = out_valid ? instr0 : '0;

  always_comb begin
    br_target = branch_addr & ~32'd3;
    pop       = out_valid && out_ready && !branch_taken;
    push      = !branch_taken && (state == RUN) && en && (pc <= LAST_ADDR) &&
                ((count != 2'd2) || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      count       <= '0;
      pc0         <= '0;
      instr0      <= '0;
      pc1         <= '0;
      instr1      <= '0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      pc     <= br_target;
      count  <= '0;
      pc0    <= '0;
      instr0 <= '0;
      pc1    <= '0;
      instr1 <= '0;
      if (state == DONE && br_target <= LAST_ADDR) state <= RUN;
    end else begin
      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (!en)                           state <= IDLE;
          else if (pc > LAST_ADDR)           state <= DONE;
          else if (push && pc == LAST_ADDR)  state <= DONE;
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase

      if (push) begin
        pc <= pc + 32'd4;
        if (fetch_count != '1) fetch_count <= fetch_count + 16'd1;
      end

      // Entry 1 is held at zero whenever unoccupied so the head shifts in zeros on drain
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            pc0    <= pc1;
            instr0 <= instr1;
            pc1    <= pc;
            instr1 <= imem_instr;
          end else begin
            pc0    <= pc;
            instr0 <= imem_instr;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            pc0    <= pc;
            instr0 <= imem_instr;
          end else begin
            pc1    <= pc;
            instr1 <= imem_instr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          pc0    <= pc1;
          instr0 <= instr1;
          pc1    <= '0;
          instr1 <= '0;
          count  <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus random traffic compared
// cycle by cycle against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] LAST = 32'd20;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, branch_taken, out_ready, out_valid;
  logic [31:0] branch_addr, imem_addr, imem_instr, out_instr, out_pc;
  logic [15:0] fetch_count;

  logic        s_rst, s_en, s_branch_taken, s_out_ready, s_out_valid;
  logic [31:0] s_branch_addr, s_imem_addr, s_imem_instr, s_out_instr, s_out_pc;
  logic [15:0] s_fetch_count;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign s_imem_instr = mem_word(s_imem_addr);

  instr_fetch_ctrl #(.RESET_PC(32'd0), .LAST_ADDR(32'd20)) dut (
    .clk(clk), .rst(rst), .en(en), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_count(fetch_count)
  );

  // Long program so the counter saturates without running out of addresses
  instr_fetch_ctrl #(.RESET_PC(32'd0), .LAST_ADDR(32'hFFFF_FFF0)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .branch_taken(s_branch_taken),
    .branch_addr(s_branch_addr), .imem_addr(s_imem_addr), .imem_instr(s_imem_instr),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_instr(s_out_instr),
    .out_pc(s_out_pc), .fetch_count(s_fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      mq[$];
  int          mmode;
  logic [31:0] mpc;
  int unsigned mfc;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mmode = M_IDLE;
    mpc   = 32'd0;
    mfc   = 0;
  endtask

  task automatic model_step();
    bit do_pop, do_push;
    int nmode;
    if (branch_taken) begin
      mq.delete();
      mpc = branch_addr & ~32'd3;
      if (mmode == M_DONE && mpc <= LAST) mmode = M_RUN;
      return;
    end
    do_pop  = (mq.size() != 0) && out_ready;
    do_push = 1'b0;
    nmode   = mmode;
    if (mmode == M_IDLE) begin
      if (en) nmode = M_RUN;
    end else if (mmode == M_RUN) begin
      if (!en)             nmode = M_IDLE;
      else if (mpc > LAST) nmode = M_DONE;
      else if (mq.size() < 2 || do_pop) do_push = 1'b1;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      mq.push_back(entry_t'{mpc, mem_word(mpc)});
      if (mpc == LAST) nmode = M_DONE;
      mpc = mpc + 32'd4;
      if (mfc < 65535) mfc++;
    end
    mmode = nmode;
  endtask

  task automatic check_all();
    logic [31:0] epc, eins;
    epc  = (mq.size() != 0) ? mq[0].pc    : 32'd0;
    eins = (mq.size() != 0) ? mq[0].instr : 32'd0;
    check("out_valid",   {31'b0, out_valid}, {31'b0, (mq.size() != 0)});
    check("out_pc",      out_pc, epc);
    check("out_instr",   out_instr, eins);
    check("imem_addr",   imem_addr, mpc);
    check("fetch_count", {16'b0, fetch_count}, {16'b0, mfc[15:0]});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; branch_taken = 1'b0; branch_addr = '0; out_ready = 1'b0;
    s_rst = 1'b0; s_en = 1'b0; s_branch_taken = 1'b0; s_branch_addr = '0; s_out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_fetch_count", {16'b0, fetch_count}, 32'd0);

    // Straight run to LAST_ADDR with decode always ready
    @(negedge clk);
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i >= 2 && i <= 7) check("run_pc_seq", out_pc, 32'((i - 2) * 4));
    end
    check("run_fetch_count", {16'b0, fetch_count}, 32'd6);
    check("run_drained", {31'b0, out_valid}, 32'd0);

    // Stall with decode not ready
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    repeat (6) cycle();
    check("stall_head", out_pc, 32'd0);
    check("stall_imem_addr", imem_addr, 32'd8);
    check("stall_fetch_count", {16'b0, fetch_count}, 32'd2);
    out_ready = 1'b1;
    cycle(); check("stall_rel_4", out_pc, 32'd4);
    cycle(); check("stall_rel_8", out_pc, 32'd8);
    cycle(); check("stall_rel_12", out_pc, 32'd12);

    // Branch to unaligned target while full
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    repeat (3) cycle();
    branch_taken = 1'b1; branch_addr = 32'h0000_000E;
    cycle();
    branch_taken = 1'b0; out_ready = 1'b1;
    check("br_cleared", {31'b0, out_valid}, 32'd0);
    check("br_pc", imem_addr, 32'd12);
    cycle(); check("br_pc12", out_pc, 32'd12);
    cycle(); check("br_pc16", out_pc, 32'd16);
    cycle(); check("br_pc20", out_pc, 32'd20);
    repeat (3) cycle();

    // Branches while DONE
    branch_taken = 1'b1; branch_addr = 32'd4;
    cycle();
    branch_taken = 1'b0;
    cycle(); check("done_br_in", out_pc, 32'd4);
    repeat (6) cycle();
    branch_taken = 1'b1; branch_addr = 32'd24;
    cycle();
    branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("done_br_out", {31'b0, out_valid}, 32'd0);
    end

    // Asynchronous reset with a full buffer
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    cycle();
    branch_taken = 1'b1; branch_addr = 32'd8;
    cycle();
    branch_taken = 1'b0;
    repeat (3) cycle();
    check("pre_rst_pc", imem_addr, 32'd16);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_valid", {31'b0, out_valid}, 32'd0);
    check("async_pc", out_pc, 32'd0);
    check("async_instr", out_instr, 32'd0);
    check("async_imem", imem_addr, 32'd0);
    check_all();
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) cycle();
    check("idle_no_push", {16'b0, fetch_count}, 32'd0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en           = ($urandom_range(0, 9) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      branch_addr  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 28));
      cycle();
    end
    branch_taken = 1'b0;

    // Counter saturation on the long-program instance
    @(negedge clk);
    s_rst = 1'b1; s_en = 1'b1; s_out_ready = 1'b1;
    s_branch_taken = 1'b1; s_branch_addr = 32'd0;
    @(posedge clk); #1;
    s_branch_taken = 1'b0;
    @(posedge clk); #1;
    check("sat_start", {16'b0, s_fetch_count}, 32'd0);
    for (int i = 1; i <= 65540; i++) begin
      @(posedge clk); #1;
      if (i == 1)     check("sat_first", {16'b0, s_fetch_count}, 32'd1);
      if (i == 65534) check("sat_pre", {16'b0, s_fetch_count}, 32'h0000_FFFE);
      if (i == 65535) check("sat_hit", {16'b0, s_fetch_count}, 32'h0000_FFFF);
      if (i == 65540) begin
        check("sat_hold", {16'b0, s_fetch_count}, 32'h0000_FFFF);
        check("sat_head_pc", s_out_pc, 32'((i - 1) * 4));
        check("sat_head_instr", s_out_instr, mem_word(32'((i - 1) * 4)));
        check("sat_valid", {31'b0, s_out_valid}, 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
